sobel_stream: RTL and testbench



---
 rtl/sobel_stream.sv | 202 ++++++++++++++++++++
 tb/tb_sobel_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge stage feeding a frame BRAM write port.
// Define SOBEL_THRESH_EN for binary edges (mag >= THRESH) instead of scaled magnitude.
module sobel_stream #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int SHIFT  = 2,
  parameter int THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [18:0] in_addr,
  input  logic [3:0]  in_pixel,
  output logic        out_we,
  output logic [18:0] out_addr,
  output logic [3:0]  out_pixel,
  output logic        busy,
  output logic        frame_done,
  output logic        resync
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [18:0] IDX_LAST = 19'(WIDTH * HEIGHT - 1);
  localparam logic [18:0] IDX_FIRST = 19'(WIDTH + 1);
  localparam logic [18:0] FLUSH_BASE = 19'(WIDTH * HEIGHT - WIDTH - 1);
  localparam logic [7:0] THR = 8'(THRESH);
`ifdef SOBEL_THRESH_EN
  localparam bit THR_MODE = 1'b1;
`else
  localparam bit THR_MODE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t state, state_next;

  logic [3:0] lb1 [WIDTH];
  logic [3:0] lb2 [WIDTH];

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [18:0] idx, cur_idx;
  logic start, abort, accept;
  logic drain_cnt;
  logic [18:0] flush_addr;

  logic [3:0] p00, p10, p20, p01, p11, p21;
  logic [3:0] p02, p12, p22;
  logic [7:0] sx_pos, sx_neg, sy_pos, sy_neg;
  logic signed [7:0] gx_c, gy_c;

  logic signed [7:0] gx, gy;
  logic s1_valid, s1_border;
  logic [18:0] s1_addr;

  logic [7:0] ax, ay, mag, sh;
  logic [3:0] sat, pix;

  // A frame start is honoured in every state and always becomes pixel 0.
  assign start = in_valid && (in_addr == '0);
  assign abort = start && (state != IDLE);
  assign accept = start || (in_valid && state == RUN);
  assign cur_col = start ? '0 : col;
  assign cur_row = start ? '0 : row;
  assign cur_idx = start ? '0 : idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start) state_next = RUN;
        else if (in_valid && idx == IDX_LAST) state_next = DRAIN;
      end
      DRAIN: begin
        if (start) state_next = RUN;
        else if (drain_cnt) state_next = FLUSH;
      end
      FLUSH: begin
        if (start) state_next = RUN;
        else if (flush_addr == IDX_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      idx <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
      idx <= cur_idx + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= 1'b0;
      flush_addr <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      flush_addr <= (state == FLUSH) ? flush_addr + 19'd1 : FLUSH_BASE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= in_pixel;
    end
  end

  assign p02 = lb2[cur_col];
  assign p12 = lb1[cur_col];
  assign p22 = in_pixel;

  // Gradients use the window as it will be after this pixel shifts in.
  assign sx_pos = {4'd0, p02} + {3'd0, p12, 1'b0} + {4'd0, p22};
  assign sx_neg = {4'd0, p00} + {3'd0, p10, 1'b0} + {4'd0, p20};
  assign sy_pos = {4'd0, p20} + {3'd0, p21, 1'b0} + {4'd0, p22};
  assign sy_neg = {4'd0, p00} + {3'd0, p01, 1'b0} + {4'd0, p02};
  assign gx_c = signed'(sx_pos - sx_neg);
  assign gy_c = signed'(sy_pos - sy_neg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p00 <= '0; p10 <= '0; p20 <= '0;
      p01 <= '0; p11 <= '0; p21 <= '0;
      gx <= '0;
      gy <= '0;
      s1_valid <= 1'b0;
      s1_border <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_valid <= accept && !start && (idx >= IDX_FIRST);
      if (accept) begin
        p00 <= p01; p10 <= p11; p20 <= p21;
        p01 <= p02; p11 <= p12; p21 <= p22;
        gx <= gx_c;
        gy <= gy_c;
        s1_addr <= cur_idx - IDX_FIRST;
        s1_border <= (cur_col < COL_TWO) || (cur_row == ROW_ONE);
      end
    end
  end

  assign ax = gx[7] ? 8'(-gx) : 8'(gx);
  assign ay = gy[7] ? 8'(-gy) : 8'(gy);
  assign mag = ax + ay;
  assign sh = mag >> SHIFT;
  assign sat = (sh > 8'd15) ? 4'hF : sh[3:0];
  assign pix = THR_MODE ? ((mag >= THR) ? 4'hF : 4'h0) : sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_we <= 1'b0;
      out_addr <= '0;
      out_pixel <= '0;
      frame_done <= 1'b0;
      resync <= 1'b0;
    end else begin
      resync <= abort;
      frame_done <= 1'b0;
      if (abort) begin
        out_we <= 1'b0;
      end else if (state == FLUSH) begin
        out_we <= 1'b1;
        out_addr <= flush_addr;
        out_pixel <= '0;
        frame_done <= (flush_addr == IDX_LAST);
      end else begin
        out_we <= s1_valid;
        if (s1_valid) begin
          out_addr <= s1_addr;
          out_pixel <= s1_border ? 4'h0 : pix;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on an 8x6 frame against an image-level Sobel model.
// Covers flat/step/impulse/random frames, input gaps, abort and mid-flush reset.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); end end

module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int SH = 2;
  localparam int TH = 8;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [18:0] in_addr;
  logic [3:0] in_pixel;
  logic out_we;
  logic [18:0] out_addr;
  logic [3:0] out_pixel;
  logic busy, frame_done, resync;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0] img [N];
  logic [3:0] mem [N];
  int hits [N];
  int hits_base [N];
  int wr_cnt = 0;
  int fd_cnt = 0;
  int rs_cnt = 0;
  int fd_addr = -1;
  int last0_cyc = -1;

  sobel_stream #(.WIDTH(W), .HEIGHT(H), .SHIFT(SH), .THRESH(TH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_pixel(in_pixel),
    .out_we(out_we), .out_addr(out_addr), .out_pixel(out_pixel),
    .busy(busy), .frame_done(frame_done), .resync(resync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_we) begin
        wr_cnt <= wr_cnt + 1;
        if (out_addr < 19'(N)) begin
          hits[out_addr] <= hits[out_addr] + 1;
          mem[out_addr] <= out_pixel;
        end
        if (out_addr == 19'd0) last0_cyc <= cyc;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_addr <= int'(out_addr);
      end
      if (resync) rs_cnt <= rs_cnt + 1;
    end
  end

  function automatic int px(int r, int c);
    return int'(img[r * W + c]);
  endfunction

  function automatic int model(int a);
    int r, c, gx, gy, mag;
    r = a / W;
    c = a % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
    return (mag >= TH) ? 15 : 0;
`else
    return ((mag >> SH) > 15) ? 15 : (mag >> SH);
`endif
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_addr = 19'($urandom_range(1, 400000));
    in_pixel = 4'($urandom);
  endtask

  task automatic drive(input int n_pix, input int gap_pct, output int t9);
    t9 = -1;
    for (int i = 0; i < n_pix; i++) begin
      while (i > 0 && int'($urandom_range(99)) < gap_pct) idle_cycle();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_addr = 19'(i);
      in_pixel = img[i];
      if (i == 9) t9 = cyc;
    end
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (fd_cnt == base && k < 400) begin
      @(posedge clk);
      k++;
    end
    `CHK("frame_done_seen", fd_cnt, base + 1)
    repeat (6) @(posedge clk);
  endtask

  task automatic check_frame(input string name, input int wr_base,
                             input int exp_writes, input bit chk_hits);
    int bad_data = 0;
    int bad_hits = 0;
    `CHK({name, "_writes"}, wr_cnt - wr_base, exp_writes)
    `CHK({name, "_done_addr"}, fd_addr, N - 1)
    for (int a = 0; a < N; a++) begin
      if (mem[a] !== 4'(model(a))) begin
        bad_data++;
        $display("  %s addr %0d observed=%0d expected=%0d", name, a, mem[a], model(a));
      end
      if (chk_hits && hits[a] - hits_base[a] != 1) bad_hits++;
    end
    `CHK({name, "_data_errors"}, bad_data, 0)
    if (chk_hits) `CHK({name, "_addr_once_errors"}, bad_hits, 0)
  endtask

  task automatic run_frame(input string name, input int gap_pct, input bit chk_lat);
    int wr_base, fd_base, t9;
    wr_base = wr_cnt;
    fd_base = fd_cnt;
    hits_base = hits;
    drive(N, gap_pct, t9);
    idle_cycle();
    wait_done(fd_base);
    check_frame(name, wr_base, N, 1'b1);
    if (chk_lat) `CHK({name, "_latency"}, last0_cyc - t9, 2)
    `CHK({name, "_busy_after"}, busy, 1'b0)
  endtask

  initial begin
    int wr_base, fd_base, rs_base, t9, k, found, snap;
    for (int a = 0; a < N; a++) begin
      hits[a] = 0;
      mem[a] = 4'hX;
    end
    reset = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    `CHK("reset_out_we", out_we, 1'b0)
    `CHK("reset_out_addr", out_addr, 19'd0)
    `CHK("reset_out_pixel", out_pixel, 4'd0)
    `CHK("reset_busy", busy, 1'b0)
    `CHK("reset_frame_done", frame_done, 1'b0)
    `CHK("reset_resync", resync, 1'b0)
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++) img[i] = 4'h7;
    run_frame("uniform", 0, 1'b1);

    wr_base = wr_cnt;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_addr = 19'($urandom_range(1, 47));
      in_pixel = 4'($urandom);
    end
    idle_cycle();
    repeat (4) @(posedge clk);
    `CHK("idle_ignored_writes", wr_cnt - wr_base, 0)
    `CHK("idle_ignored_busy", busy, 1'b0)

    for (int i = 0; i < N; i++) img[i] = ((i % W) >= 4) ? 4'hF : 4'h0;
    run_frame("vstep", 0, 1'b0);

    for (int i = 0; i < N; i++) img[i] = (i == 2 * W + 2) ? 4'hF : 4'h0;
    run_frame("impulse", 0, 1'b0);

    for (int i = 0; i < N; i++) img[i] = 4'($urandom);
    run_frame("random_gaps", 30, 1'b1);

    for (int i = 0; i < N; i++) img[i] = 4'($urandom);
    run_frame("random_dense", 0, 1'b1);

    wr_base = wr_cnt;
    fd_base = fd_cnt;
    rs_base = rs_cnt;
    for (int i = 0; i < N; i++) img[i] = 4'hF;
    drive(20, 0, t9);
    for (int i = 0; i < N; i++) img[i] = 4'($urandom);
    drive(N, 0, t9);
    idle_cycle();
    wait_done(fd_base);
    check_frame("abort", wr_base, N + 10, 1'b0);
    `CHK("abort_resync_pulses", rs_cnt - rs_base, 1)

    fd_base = fd_cnt;
    for (int i = 0; i < N; i++) img[i] = 4'($urandom);
    drive(N, 0, t9);
    idle_cycle();
    found = 0;
    k = 0;
    while (found == 0 && k < 400) begin
      @(negedge clk);
      if (out_we && out_addr == 19'd41) found = 1;
      k++;
    end
    `CHK("flush_reached", found, 1)
    `CHK("flush_busy", busy, 1'b1)
    reset = 1'b1;
    #1;
    `CHK("midreset_out_we", out_we, 1'b0)
    `CHK("midreset_busy", busy, 1'b0)
    `CHK("midreset_out_addr", out_addr, 19'd0)
    `CHK("midreset_frame_done", frame_done, 1'b0)
    snap = wr_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    `CHK("postreset_no_writes", wr_cnt - snap, 0)
    `CHK("postreset_no_done", fd_cnt - fd_base, 0)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
